// File: rtl/mean_scheduler.sv
// Round-robin scheduler that time-shares one frame-mean accumulator among NCH
// sample requesters; each grant collects 2^LOG2N samples and emits their mean.
module mean_scheduler #(
  parameter  int NCH   = 4,
  parameter  int LOG2N = 11,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [16*NCH-1:0] ch_data,
  output logic [NCH-1:0]    ch_ready,
  output logic              mean_valid,
  input  logic              mean_ready,
  output logic [15:0]       mean_out,
  output logic [CW-1:0]     mean_ch,
  output logic              busy
);

  localparam int AW = 16 + LOG2N;
  localparam logic [LOG2N:0]   LAST_CNT = (LOG2N + 1)'((1 << LOG2N) - 1);
  localparam logic [NCH-1:0]   ONE_HOT0 = NCH'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  state_t          state_q;
  logic [CW-1:0]   grant_q;
  logic [CW-1:0]   last_grant_q;
  logic [AW-1:0]   acc_q;
  logic [LOG2N:0]  cnt_q;
  logic [NCH-1:0]  ch_ready_q;
  logic            mean_valid_q;
  logic [15:0]     mean_out_q;
  logic [CW-1:0]   mean_ch_q;

  logic            grant_found;
  logic [CW-1:0]   grant_d;
  logic [CW-1:0]   cand;
  logic [15:0]     samples [NCH];
  logic [15:0]     sel_sample;
  logic [AW-1:0]   acc_d;
  logic            accept;

  // Round-robin search starting one past the channel served last.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_d     = last_grant_q;
    cand        = last_grant_q;
    for (int i = 1; i <= NCH; i++) begin
      cand = CW'((int'(last_grant_q) + i) % NCH);
      if (!grant_found && ch_valid[cand]) begin
        grant_found = 1'b1;
        grant_d     = cand;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      samples[k] = ch_data[16*k +: 16];
    end
    sel_sample = samples[grant_q];
    acc_d      = acc_q + {{LOG2N{sel_sample[15]}}, sel_sample};
    accept     = (state_q == ACCUM) && ch_valid[grant_q] && ch_ready_q[grant_q];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(NCH - 1);
      acc_q        <= '0;
      cnt_q        <= '0;
      ch_ready_q   <= '0;
      mean_valid_q <= 1'b0;
      mean_out_q   <= '0;
      mean_ch_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            state_q    <= ACCUM;
            grant_q    <= grant_d;
            ch_ready_q <= ONE_HOT0 << grant_d;
            acc_q      <= '0;
            cnt_q      <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_q      <= RESULT;
              ch_ready_q   <= '0;
              mean_out_q   <= acc_d[LOG2N +: 16];
              mean_ch_q    <= grant_q;
              mean_valid_q <= 1'b1;
            end
          end
        end
        RESULT: begin
          if (mean_ready) begin
            state_q      <= IDLE;
            mean_valid_q <= 1'b0;
            last_grant_q <= grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_ready   = ch_ready_q;
  assign mean_valid = mean_valid_q;
  assign mean_out   = mean_out_q;
  assign mean_ch    = mean_ch_q;
  assign busy       = (state_q != IDLE);

endmodule
